vl53l0x_init_sequencer: RTL



---
 rtl/vl53l0x_init_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vl53l0x_init_sequencer.sv
// VL53L0X init sequencer: walks an external (reg, data, delay) table and issues
// each entry through the single-register write engine with watchdog and retries.
module vl53l0x_init_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h29,
    parameter int         NUM_ENTRIES    = 16,
    parameter int         MAX_RETRIES    = 3,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         DELAY_UNIT     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_index,
    output logic [7:0] tbl_index,
    input  logic [7:0] tbl_reg,
    input  logic [7:0] tbl_data,
    input  logic [3:0] tbl_delay,
    output logic [6:0] wr_dev_address,
    output logic [7:0] wr_reg_address,
    output logic [7:0] wr_data,
    output logic       wr_start,
    input  logic       wr_done,
    input  logic       wr_failure
);
    localparam int DW = 4 + $clog2(DELAY_UNIT + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] UNIT      = DW'(DELAY_UNIT);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX  = 8'(NUM_ENTRIES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT, DELAY, NEXT, FINISH, FAIL
    } state_t;

    state_t        state;
    logic [3:0]    retries;
    logic [3:0]    dly_reg;
    logic [DW-1:0] dly_cnt;
    logic [WW-1:0] wd_cnt;
    logic          attempt_failed;

    assign wr_dev_address = DEV_ADDR;

    // A failure pulse beats a simultaneous done; a done beats a simultaneous timeout.
    assign attempt_failed = wr_failure || (!wr_done && wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_index      <= 8'd0;
            tbl_index      <= 8'd0;
            wr_reg_address <= 8'd0;
            wr_data        <= 8'd0;
            wr_start       <= 1'b0;
            retries        <= 4'd0;
            dly_reg        <= 4'd0;
            dly_cnt        <= '0;
            wd_cnt         <= '0;
        end else begin
            done     <= 1'b0;
            wr_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    error     <= 1'b0;
                    tbl_index <= 8'd0;
                    retries   <= 4'd0;
                    busy      <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: begin
                    wr_reg_address <= tbl_reg;
                    wr_data        <= tbl_data;
                    dly_reg        <= tbl_delay;
                    wr_start       <= 1'b1;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (attempt_failed) begin
                        // Retries reuse the latched register/data; no re-fetch.
                        if (retries < RETRY_MAX) begin
                            retries  <= retries + 4'd1;
                            wr_start <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            state <= FAIL;
                        end
                    end else if (wr_done) begin
                        dly_cnt <= DW'(dly_reg) * UNIT;
                        state   <= DELAY;
                    end else if (wd_cnt != WD_LAST) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) state <= NEXT;
                    else dly_cnt <= dly_cnt - 1'b1;
                end
                NEXT: begin
                    if (tbl_index == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        tbl_index <= tbl_index + 8'd1;
                        retries   <= 4'd0;
                        state     <= FETCH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAIL: begin
                    error     <= 1'b1;
                    err_index <= tbl_index;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
